// File: rtl/ahb_xip_rdbuf.sv
// AHB-Lite read buffer in front of a 64-bit XIP flash controller.
// Holds one doubleword, answers hits with zero wait states and rejects writes with ERROR.
module ahb_xip_rdbuf #(
  parameter int TAG_W = 21,
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  output logic             M_HSEL,
  output logic [31:0]      M_HADDR,
  output logic [1:0]       M_HTRANS,
  output logic             M_HWRITE,
  output logic             M_HREADY,
  input  logic             M_HREADYOUT,
  input  logic [63:0]      M_HRDATA,
  input  logic             INV,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] CNT_HIT,
  output logic [CNT_W-1:0] CNT_MISS
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, ERR1, ERR2} state_e;

  state_e             state_q, state_d;
  logic [31:2]        addr_q, addr_d;
  logic               write_q, write_d;
  logic               hit_q, hit_d;
  logic [63:0]        buf_q, buf_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   hitCnt_q, hitCnt_d;
  logic [CNT_W-1:0]   missCnt_q, missCnt_d;
  logic               hreadyout_q, hreadyout_d;
  logic               hresp_q, hresp_d;
  logic               mSel_q, mSel_d;
  logic [31:0]        mAddr_q, mAddr_d;

  logic               xferValid;
  logic               canAccept;
  logic               newXfer;
  logic               lookupHit;
  logic               readHit;
  logic               readMiss;
  logic               load;

  // Lookup uses the valid bit as it stands this cycle, so a same-cycle INV cannot turn a hit into a miss.
  always_comb begin
    xferValid = HSEL & HREADY & HTRANS[1];
    canAccept = (state_q == IDLE) || (state_q == RESP) || (state_q == ERR2);
    newXfer   = canAccept & xferValid;
    lookupHit = valid_q && (tag_q == HADDR[TAG_W+2:3]);
    readHit   = newXfer & ~HWRITE & lookupHit;
    readMiss  = newXfer & ~HWRITE & ~lookupHit;
    load      = (state_q == DATA) & M_HREADYOUT;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP, ERR2: begin
        if (newXfer && HWRITE)   state_d = ERR1;
        else if (readMiss)       state_d = ADDR;
        else                     state_d = IDLE;
      end
      ADDR:    state_d = M_HREADYOUT ? DATA : ADDR;
      DATA:    state_d = M_HREADYOUT ? RESP : DATA;
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = newXfer ? HADDR[31:2] : addr_q;
    write_d   = newXfer ? HWRITE : write_q;
    hit_d     = newXfer ? lookupHit : hit_q;
    buf_d     = load ? M_HRDATA : buf_q;
    tag_d     = load ? addr_q[TAG_W+2:3] : tag_q;
    valid_d   = INV ? 1'b0 : (load ? 1'b1 : valid_q);

    hitCnt_d  = hitCnt_q;
    missCnt_d = missCnt_q;
    if (CNT_CLR) begin
      hitCnt_d  = '0;
      missCnt_d = '0;
    end else begin
      if (readHit && (hitCnt_q != '1))   hitCnt_d  = hitCnt_q + CNT_W'(1);
      if (readMiss && (missCnt_q != '1)) missCnt_d = missCnt_q + CNT_W'(1);
    end

    hreadyout_d = !((state_d == ADDR) || (state_d == DATA) || (state_d == ERR1));
    hresp_d     = (state_d == ERR1) || (state_d == ERR2);
    mSel_d      = (state_d == ADDR);
    mAddr_d     = (state_d == ADDR) ? {addr_d[31:3], 3'b000} : 32'h0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      hit_q       <= 1'b0;
      buf_q       <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      hitCnt_q    <= '0;
      missCnt_q   <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      mSel_q      <= 1'b0;
      mAddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      hit_q       <= hit_d;
      buf_q       <= buf_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      hitCnt_q    <= hitCnt_d;
      missCnt_q   <= missCnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      mSel_q      <= mSel_d;
      mAddr_q     <= mAddr_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = addr_q[2] ? buf_q[63:32] : buf_q[31:0];
  assign M_HSEL    = mSel_q;
  assign M_HADDR   = mAddr_q;
  assign M_HTRANS  = mSel_q ? 2'b10 : 2'b00;
  assign M_HWRITE  = 1'b0;
  assign M_HREADY  = M_HREADYOUT;
  assign CNT_HIT   = hitCnt_q;
  assign CNT_MISS  = missCnt_q;

  // Registered for debug visibility; the FSM decides from the live address phase.
  logic unusedOk;
  assign unusedOk = ^{HADDR[1:0], HTRANS[0], write_q, hit_q};

endmodule

// File: tb/tb_ahb_xip_rdbuf.sv
// Directed bench for ahb_xip_rdbuf; a second instance with 4-bit counters exercises saturation.
module tb_ahb_xip_rdbuf;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic        hready;
  logic        hreadyOut;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mSel;
  logic [31:0] mAddr;
  logic [1:0]  mTrans;
  logic        mWrite;
  logic        mReady;
  logic        mReadyOut;
  logic [63:0] mRdata;
  logic        inv;
  logic        cntClr;
  logic [15:0] hitCnt;
  logic [15:0] missCnt;

  logic        smallReadyOut, smallResp, smallSel, smallWrite, smallReady;
  logic [31:0] smallRdata, smallAddr;
  logic [1:0]  smallTrans;
  logic [3:0]  smallHit, smallMiss;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  // The upstream interconnect feeds our own ready back, so address phases stall during wait states.
  assign hready = hreadyOut;

  ahb_xip_rdbuf dut (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HREADY(hready), .HREADYOUT(hreadyOut), .HRESP(hresp),
    .HRDATA(hrdata), .M_HSEL(mSel), .M_HADDR(mAddr), .M_HTRANS(mTrans),
    .M_HWRITE(mWrite), .M_HREADY(mReady), .M_HREADYOUT(mReadyOut),
    .M_HRDATA(mRdata), .INV(inv), .CNT_CLR(cntClr), .CNT_HIT(hitCnt),
    .CNT_MISS(missCnt)
  );

  ahb_xip_rdbuf #(.TAG_W(21), .CNT_W(4)) dutSmall (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HREADY(hready), .HREADYOUT(smallReadyOut), .HRESP(smallResp),
    .HRDATA(smallRdata), .M_HSEL(smallSel), .M_HADDR(smallAddr), .M_HTRANS(smallTrans),
    .M_HWRITE(smallWrite), .M_HREADY(smallReady), .M_HREADYOUT(mReadyOut),
    .M_HRDATA(mRdata), .INV(inv), .CNT_CLR(cntClr), .CNT_HIT(smallHit),
    .CNT_MISS(smallMiss)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [31:0] addr, input logic [1:0] trans, input logic wr);
    hsel   = sel;
    haddr  = addr;
    htrans = trans;
    hwrite = wr;
  endtask

  // Issues one NONSEQ read, then idles the bus and waits for the data phase to complete.
  task automatic runRead(input string tag, input logic [31:0] addr, input int expWaits,
                         input logic [31:0] expData, input int expFetches);
    int waits;
    int fetches;
    logic [31:0] fetchAddr;
    applyStimulus(1'b1, addr, 2'b10, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    waits = 0;
    fetches = 0;
    fetchAddr = 32'h0;
    while (!hreadyOut && waits < 50) begin
      if (mTrans == 2'b10) begin
        fetches++;
        fetchAddr = mAddr;
      end
      waits++;
      tick();
    end
    checkOutput({tag, " waits"}, 64'(waits), 64'(expWaits));
    checkOutput({tag, " hrdata"}, 64'(hrdata), 64'(expData));
    checkOutput({tag, " hresp"}, 64'(hresp), 64'(0));
    checkOutput({tag, " fetches"}, 64'(fetches), 64'(expFetches));
    if (expFetches > 0)
      checkOutput({tag, " fetch addr"}, 64'(fetchAddr), 64'({addr[31:3], 3'b000}));
  endtask

  initial begin
    int low;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    hreset = 1'b1;
    mReadyOut = 1'b1;
    mRdata = 64'h0;
    inv = 1'b0;
    cntClr = 1'b0;
    repeat (2) tick();
    checkOutput("reset hreadyout", 64'(hreadyOut), 64'(1));
    checkOutput("reset hresp", 64'(hresp), 64'(0));
    checkOutput("reset m_hsel", 64'(mSel), 64'(0));
    checkOutput("reset m_htrans", 64'(mTrans), 64'(0));
    checkOutput("reset cnt_hit", 64'(hitCnt), 64'(0));
    checkOutput("reset cnt_miss", 64'(missCnt), 64'(0));
    hreset = 1'b0;

    // Cold miss, then a hit on the low word of the same doubleword.
    mRdata = 64'h1111_2222_3333_4444;
    runRead("cold read", 32'h0000_0104, 2, 32'h1111_2222, 1);
    checkOutput("cold cnt_miss", 64'(missCnt), 64'(1));
    runRead("hit read", 32'h0000_0100, 0, 32'h3333_4444, 0);
    checkOutput("hit cnt_hit", 64'(hitCnt), 64'(1));
    checkOutput("hit cnt_miss", 64'(missCnt), 64'(1));
    checkOutput("m_hwrite tied", 64'(mWrite), 64'(0));

    // Slow downstream: DATA lasts five cycles (four stalled), then a read pipelined in RESP.
    mRdata = 64'hAAAA_BBBB_CCCC_DDDD;
    applyStimulus(1'b1, 32'h0000_0200, 2'b10, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    low = 0;
    while (!hreadyOut && low < 50) begin
      low++;
      if (low == 2) mReadyOut = 1'b0;
      if (low == 6) mReadyOut = 1'b1;
      checkOutput("slow m_hready follows", 64'(mReady), 64'(mReadyOut));
      tick();
    end
    checkOutput("slow wait states", 64'(low), 64'(6));
    checkOutput("slow hrdata", 64'(hrdata), 64'(32'hCCCC_DDDD));
    mRdata = 64'h5555_6666_7777_8888;
    applyStimulus(1'b1, 32'h0000_0108, 2'b10, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("b2b m_htrans", 64'(mTrans), 64'(2'b10));
    checkOutput("b2b m_haddr", 64'(mAddr), 64'(32'h0000_0108));
    checkOutput("b2b hreadyout", 64'(hreadyOut), 64'(0));
    low = 0;
    while (!hreadyOut && low < 50) begin
      low++;
      tick();
    end
    checkOutput("b2b hrdata", 64'(hrdata), 64'(32'h7777_8888));
    checkOutput("b2b cnt_miss", 64'(missCnt), 64'(3));

    // Write gets a two-cycle ERROR response and never reaches the flash side.
    applyStimulus(1'b1, 32'h0000_0000, 2'b10, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("err1 hreadyout", 64'(hreadyOut), 64'(0));
    checkOutput("err1 hresp", 64'(hresp), 64'(1));
    checkOutput("err1 m_htrans", 64'(mTrans), 64'(0));
    tick();
    checkOutput("err2 hreadyout", 64'(hreadyOut), 64'(1));
    checkOutput("err2 hresp", 64'(hresp), 64'(1));
    checkOutput("err2 m_htrans", 64'(mTrans), 64'(0));
    tick();
    checkOutput("post err hresp", 64'(hresp), 64'(0));
    checkOutput("write no count", 64'(missCnt), 64'(3));

    // BUSY and deselected transfers are answered OKAY with no wait.
    applyStimulus(1'b1, 32'h0000_0400, 2'b01, 1'b0);
    tick();
    checkOutput("busy hreadyout", 64'(hreadyOut), 64'(1));
    checkOutput("busy m_htrans", 64'(mTrans), 64'(0));
    applyStimulus(1'b0, 32'h0000_0400, 2'b10, 1'b0);
    tick();
    checkOutput("nosel hreadyout", 64'(hreadyOut), 64'(1));
    checkOutput("nosel hresp", 64'(hresp), 64'(0));
    checkOutput("nosel m_htrans", 64'(mTrans), 64'(0));
    checkOutput("idle no count", 64'(missCnt), 64'(3));
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);

    // INV on the load cycle: data still delivered, buffer left invalid.
    mRdata = 64'h9999_AAAA_BBBB_CCCC;
    applyStimulus(1'b1, 32'h0000_0300, 2'b10, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    checkOutput("inv load hreadyout", 64'(hreadyOut), 64'(1));
    checkOutput("inv load hrdata", 64'(hrdata), 64'(32'hBBBB_CCCC));
    runRead("after inv", 32'h0000_0300, 2, 32'hBBBB_CCCC, 1);
    checkOutput("after inv cnt_miss", 64'(missCnt), 64'(5));

    // Reset lands while the fetch is in DATA; the late downstream ready must be ignored.
    applyStimulus(1'b1, 32'h0000_0500, 2'b10, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    tick();
    checkOutput("pre reset hreadyout", 64'(hreadyOut), 64'(0));
    hreset = 1'b1;
    mReadyOut = 1'b0;
    tick();
    hreset = 1'b0;
    checkOutput("mid reset hreadyout", 64'(hreadyOut), 64'(1));
    checkOutput("mid reset m_htrans", 64'(mTrans), 64'(0));
    checkOutput("mid reset cnt_miss", 64'(missCnt), 64'(0));
    mReadyOut = 1'b1;
    tick();
    checkOutput("late ready hreadyout", 64'(hreadyOut), 64'(1));
    checkOutput("late ready m_htrans", 64'(mTrans), 64'(0));
    runRead("post reset", 32'h0000_0300, 2, 32'hBBBB_CCCC, 1);
    checkOutput("post reset cnt_miss", 64'(missCnt), 64'(1));

    // Saturation of the 4-bit hit counter.
    cntClr = 1'b1;
    tick();
    cntClr = 1'b0;
    checkOutput("clr cnt_hit", 64'(hitCnt), 64'(0));
    checkOutput("clr small miss", 64'(smallMiss), 64'(0));
    for (int i = 0; i < 16; i++)
      runRead("sat hit", 32'h0000_0304, 0, 32'h9999_AAAA, 0);
    checkOutput("sat small hit", 64'(smallHit), 64'(4'hF));
    checkOutput("sat big hit", 64'(hitCnt), 64'(16));
    runRead("sat extra", 32'h0000_0304, 0, 32'h9999_AAAA, 0);
    checkOutput("sat held small", 64'(smallHit), 64'(4'hF));
    checkOutput("sat held big", 64'(hitCnt), 64'(17));

    // Clear wins over a same-cycle hit.
    applyStimulus(1'b1, 32'h0000_0304, 2'b10, 1'b0);
    cntClr = 1'b1;
    tick();
    cntClr = 1'b0;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("clr prio hit", 64'(hitCnt), 64'(0));
    checkOutput("clr prio small", 64'(smallHit), 64'(0));
    checkOutput("clr prio ready", 64'(hreadyOut), 64'(1));

    // INV alongside a lookup still hits, but the following read misses.
    applyStimulus(1'b1, 32'h0000_0300, 2'b10, 1'b0);
    inv = 1'b1;
    tick();
    inv = 1'b0;
    applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
    checkOutput("inv hit ready", 64'(hreadyOut), 64'(1));
    checkOutput("inv hit hrdata", 64'(hrdata), 64'(32'hBBBB_CCCC));
    checkOutput("inv hit cnt", 64'(hitCnt), 64'(1));
    runRead("inv then miss", 32'h0000_0300, 2, 32'hBBBB_CCCC, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
